// File: rtl/reg_bank_ab_pkg.sv
// rtl/reg_bank_ab_pkg.sv - shared widths, stack pointer reset and register index constants
package reg_bank_ab_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int SP_IDX     = 29;
   localparam int SP_RESET   = 227;

   localparam int REG_ZERO   = 0;
   localparam int REG_SP     = 29;

endpackage

// File: rtl/reg_bank_ab_latch.sv
// rtl/reg_bank_ab_latch.sv - load-enable operand register with async active-low clear
module reg_bank_ab_latch #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/reg_bank_ab.sv
// rtl/reg_bank_ab.sv - register bank with bypassed A/B operand latches and write counter
module reg_bank_ab #(
   parameter int DATA_W   = reg_bank_ab_pkg::DATA_W_DEF,
   parameter int ADDR_W   = reg_bank_ab_pkg::ADDR_W_DEF,
   parameter int SP_IDX   = reg_bank_ab_pkg::SP_IDX,
   parameter int SP_RESET = reg_bank_ab_pkg::SP_RESET
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              reg_wr,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic              ab_load,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [7:0]        wr_count
);

   import reg_bank_ab_pkg::*;

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [NREGS];
   logic              wr_en;
   logic [DATA_W-1:0] a_next;
   logic [DATA_W-1:0] b_next;

   // Writes to the zero register are dropped entirely, including from the count.
   assign wr_en = reg_wr && (wr_addr != ADDR_W'(REG_ZERO));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            mem[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_count <= '0;
      end else if (wr_en) begin
         wr_count <= wr_count + 8'd1;
      end
   end

   // Raw ports show stored contents only; the in-flight write is visible after the edge.
   assign rs_data = (rs_addr == ADDR_W'(REG_ZERO)) ? '0 : mem[rs_addr];
   assign rt_data = (rt_addr == ADDR_W'(REG_ZERO)) ? '0 : mem[rt_addr];

   // A/B forward the same-edge write so the operands never latch a stale value.
   always_comb begin
      a_next = rs_data;
      b_next = rt_data;
      if (wr_en && (wr_addr == rs_addr)) begin
         a_next = wr_data;
      end
      if (wr_en && (wr_addr == rt_addr)) begin
         b_next = wr_data;
      end
   end

   reg_bank_ab_latch #(.W(DATA_W)) u_latch_a (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (ab_load),
      .d       (a_next),
      .q       (a_out)
   );

   reg_bank_ab_latch #(.W(DATA_W)) u_latch_b (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (ab_load),
      .d       (b_next),
      .q       (b_out)
   );

endmodule
